dataint_ecc_hamming_decode_secded_pipe: RTL
===========================================

Name: dataint_ecc_hamming_decode_secded_pipe

Overview:
- Pipelined SECDED checker/corrector that sits directly downstream of the Hamming SECDED encoder, typically after storage or a link.
- Accepts encoded codewords on a valid/ready stream, corrects single-bit errors and flags double-bit errors.
- Emits corrected data plus per-word status, and keeps saturating error counters for CSR visibility.

Parameters:
- WIDTH, 32, data bits per codeword.
- COUNT_W, 16, width of each saturating error counter.
- ParityBits (localparam), $clog2(WIDTH+$clog2(WIDTH)+1), number of Hamming parity bits.
- TotalWidth (localparam), WIDTH+ParityBits+1, codeword width including the overall parity bit.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  input codeword valid
- o_ready  out  1  block can accept
- i_encoded_data  in  TotalWidth  codeword
- o_valid  out  1  output valid
- i_ready  in  1  downstream accepts
- o_data  out  WIDTH  corrected data
- o_err_single  out  1  word had a single-bit error, corrected
- o_err_double  out  1  word uncorrectable
- o_syndrome  out  ParityBits  raw syndrome of the word
- i_cnt_clear  in  1  clear both counters
- o_cnt_single  out  COUNT_W  corrected-word count
- o_cnt_double  out  COUNT_W  uncorrectable-word count

Behaviour:
- Interface: one clock, i_clk; reset is synchronous and active-high, i_rst. All state updates on posedge i_clk.
- Codeword layout (must match the encoder):
  - Parity bit i sits at index 2^i-1.
  - Data bits fill the remaining indices [0..TotalWidth-2] in ascending order.
  - Index TotalWidth-1 holds the XOR of bits [TotalWidth-2:0].
- Stage 1 (S1) registers the codeword and computes:
  - syndrome s[i] = XOR of bits j where ((j+1)>>i)&1;
  - overall parity op = XOR of all TotalWidth bits.
- Stage 2 (S2) registers the corrected data and status.
- Latency: 2 cycles from accept to o_valid when not stalled. Throughput: 1 word/cycle.
- Classification:
  - s==0, op==0: clean.
  - s!=0, op==1, s<=TotalWidth-1: single error; flip bit s-1, set o_err_single.
  - s==0, op==1: single error in the overall parity bit; data unchanged, set o_err_single.
  - s!=0, op==0: double error; set o_err_double, pass o_data uncorrected.
  - s!=0, op==1, s>TotalWidth-1: treat as double error.
- Handshake:
  - Each stage holds its valid and payload until the next stage takes it.
  - stage_ready = !stage_valid || next_ready, and o_ready = S1 ready.
  - A transfer occurs on valid&&ready. The payload is stable while o_valid && !i_ready.
- Counters:
  - Each counter increments by 1 on the output transfer (o_valid&&i_ready) of a word carrying the matching flag.
  - Each counter saturates at all-ones.
  - i_cnt_clear zeroes both counters; clear wins over a simultaneous increment.
- Reset values:
  - o_valid=0 and both stage valids 0.
  - o_data, o_syndrome, o_err_single, o_err_double = 0.
  - Counters = 0.
  - o_ready=1 in the first cycle after reset deasserts; o_ready is 0 while i_rst is high.
- Reset mid-operation: in-flight words are discarded and are not counted.

Optional Feature:
- Macro: DATAINT_ECC_ERR_LOG_EN.
- Defined: adds outputs o_log_valid (1 bit), o_log_syndrome (ParityBits) and o_log_double (1 bit).
  - The first erroneous word transferred after reset or i_cnt_clear latches its syndrome and double flag, and sets o_log_valid.
  - Later errors do not overwrite the log until the next clear.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package dataint_ecc_pkg holds:
  - functions ecc_parity_bits(width) and ecc_total_width(width);
  - function ecc_is_parity_pos(idx);
  - typedef enum ecc_status_e {ECC_CLEAN, ECC_SINGLE, ECC_DOUBLE}.
- One natural sub-module: dataint_ecc_secded_syndrome, a combinational syndrome/op generator instanced in S1. The same sub-module is reusable by the encoder side.

Test Plan (WIDTH=4, TotalWidth=8, data at idx 2,4,5,6):
- Clean word: send 0x55 (data 4'b1011) -> 2 cycles later o_data=4'hB, both error flags 0, o_syndrome=0, counters unchanged.
- Single data error: send 0x45 (bit 4 flipped) -> o_data=4'hB, o_err_single=1, o_syndrome=5, o_cnt_single=1.
- Overall-parity error: send 0xD5 (bit 7 flipped) -> o_data=4'hB, o_err_single=1, o_syndrome=0.
- Double error: send 0x56 (bits 0,1 flipped) -> o_err_double=1, o_syndrome=3, o_cnt_double=1, o_data not corrected.
- Backpressure:
  - Stream 4 words with i_ready=0 for 5 cycles -> o_ready drops after 2 words accepted, o_data held stable.
  - On release, words emerge in order with no loss or duplication.
- Saturation and clear:
  - COUNT_W=2, 5 single-error words -> o_cnt_single=3.
  - i_cnt_clear asserted together with an error transfer -> counter reads 0.
  - Reset asserted mid-stream -> o_valid=0 next cycle.

Source files
------------

// File: rtl/dataint_ecc_pkg.sv
// rtl/dataint_ecc_pkg.sv - shared SECDED geometry helpers and status type
package dataint_ecc_pkg;

    typedef enum logic [1:0] {
        ECC_CLEAN  = 2'd0,
        ECC_SINGLE = 2'd1,
        ECC_DOUBLE = 2'd2
    } ecc_status_e;

    // Hamming parity bits needed to cover width data bits.
    function automatic int ecc_parity_bits(input int width);
        return $clog2(width + $clog2(width) + 1);
    endfunction

    // Full codeword width: data + Hamming parity + overall parity bit.
    function automatic int ecc_total_width(input int width);
        return width + ecc_parity_bits(width) + 1;
    endfunction

    // Hamming parity bits live at indices 2^i-1, i.e. where idx+1 is a power of two.
    function automatic logic ecc_is_parity_pos(input int idx);
        int v;
        v = idx + 1;
        return ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/dataint_ecc_secded_syndrome.sv
// rtl/dataint_ecc_secded_syndrome.sv - combinational Hamming syndrome and overall parity
module dataint_ecc_secded_syndrome #(
    parameter int TOTAL_W = 8,
    parameter int PAR_W   = 3
) (
    input  logic [TOTAL_W-1:0] i_codeword,
    output logic [PAR_W-1:0]   o_syndrome,
    output logic               o_overall
);

    // Syndrome bit i covers every position j (overall bit excluded) whose j+1 has bit i set.
    always_comb begin
        o_syndrome = '0;
        for (int i = 0; i < PAR_W; i++) begin
            for (int j = 0; j < TOTAL_W - 1; j++) begin
                if ((((j + 1) >> i) & 1) == 1) begin
                    o_syndrome[i] = o_syndrome[i] ^ i_codeword[j];
                end
            end
        end
        o_overall = ^i_codeword;
    end

endmodule

// File: rtl/dataint_ecc_hamming_decode_secded_pipe.sv
// rtl/dataint_ecc_hamming_decode_secded_pipe.sv - two-stage SECDED decoder with counters; optional DATAINT_ECC_ERR_LOG_EN
module dataint_ecc_hamming_decode_secded_pipe
    import dataint_ecc_pkg::*;
#(
    parameter int  WIDTH      = 32,
    parameter int  COUNT_W    = 16,
    localparam int ParityBits = ecc_parity_bits(WIDTH),
    localparam int TotalWidth = ecc_total_width(WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [TotalWidth-1:0] i_encoded_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_err_single,
    output logic                  o_err_double,
    output logic [ParityBits-1:0] o_syndrome,
    input  logic                  i_cnt_clear,
    output logic [COUNT_W-1:0]    o_cnt_single,
`ifdef DATAINT_ECC_ERR_LOG_EN
    output logic [COUNT_W-1:0]    o_cnt_double,
    output logic                  o_log_valid,
    output logic [ParityBits-1:0] o_log_syndrome,
    output logic                  o_log_double
`else
    output logic [COUNT_W-1:0]    o_cnt_double
`endif
);

    logic                  r_s1_valid;
    logic [TotalWidth-1:0] r_s1_code;
    logic [ParityBits-1:0] r_s1_syn;
    logic                  r_s1_op;

    logic                  r_s2_valid;
    logic [WIDTH-1:0]      r_data;
    logic                  r_err_single;
    logic                  r_err_double;
    logic [ParityBits-1:0] r_syndrome;

    logic [COUNT_W-1:0]    r_cnt_single;
    logic [COUNT_W-1:0]    r_cnt_double;

    logic [ParityBits-1:0] w_syn;
    logic                  w_op;
    logic                  w_s1_ready;
    logic                  w_s2_ready;
    logic                  w_out_fire;
    logic [TotalWidth-1:0] w_fixed;
    logic [WIDTH-1:0]      w_data;
    ecc_status_e           w_status;

    // Pull data bits out of the non-parity positions, lowest index first.
    function automatic logic [WIDTH-1:0] extract_data(input logic [TotalWidth-1:0] code);
        logic [WIDTH-1:0] d;
        int               k;
        d = '0;
        k = 0;
        for (int j = 0; j < TotalWidth - 1; j++) begin
            if (!ecc_is_parity_pos(j)) begin
                if (k < WIDTH) begin
                    d[k] = code[j];
                end
                k++;
            end
        end
        return d;
    endfunction

    dataint_ecc_secded_syndrome #(
        .TOTAL_W (TotalWidth),
        .PAR_W   (ParityBits)
    ) u_syndrome (
        .i_codeword (i_encoded_data),
        .o_syndrome (w_syn),
        .o_overall  (w_op)
    );

    assign w_s2_ready = !r_s2_valid || i_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign o_ready    = !i_rst && w_s1_ready;
    assign w_out_fire = r_s2_valid && i_ready;

    // S1: capture the codeword together with its syndrome and overall parity.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
            r_s1_syn   <= '0;
            r_s1_op    <= 1'b0;
        end else if (w_s1_ready) begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_code <= i_encoded_data;
                r_s1_syn  <= w_syn;
                r_s1_op   <= w_op;
            end
        end
    end

    // Classify the S1 word and flip the addressed bit for correctable errors.
    always_comb begin
        w_status = ECC_CLEAN;
        w_fixed  = r_s1_code;
        if (r_s1_syn == '0) begin
            if (r_s1_op) begin
                w_status = ECC_SINGLE;
            end
        end else if (!r_s1_op || (int'(r_s1_syn) > TotalWidth - 1)) begin
            w_status = ECC_DOUBLE;
        end else begin
            w_status = ECC_SINGLE;
            for (int j = 0; j < TotalWidth - 1; j++) begin
                if (int'(r_s1_syn) == j + 1) begin
                    w_fixed[j] = ~r_s1_code[j];
                end
            end
        end
    end

    assign w_data = extract_data(w_fixed);

    // S2: register corrected data and status; hold while downstream stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_valid   <= 1'b0;
            r_data       <= '0;
            r_err_single <= 1'b0;
            r_err_double <= 1'b0;
            r_syndrome   <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_data       <= w_data;
                r_err_single <= (w_status == ECC_SINGLE);
                r_err_double <= (w_status == ECC_DOUBLE);
                r_syndrome   <= r_s1_syn;
            end
        end
    end

    // Saturating error counters bumped on output transfer; clear takes priority.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clear) begin
            r_cnt_single <= '0;
            r_cnt_double <= '0;
        end else if (w_out_fire) begin
            if (r_err_single && (r_cnt_single != '1)) begin
                r_cnt_single <= r_cnt_single + COUNT_W'(1);
            end
            if (r_err_double && (r_cnt_double != '1)) begin
                r_cnt_double <= r_cnt_double + COUNT_W'(1);
            end
        end
    end

`ifdef DATAINT_ECC_ERR_LOG_EN
    logic                  r_log_valid;
    logic [ParityBits-1:0] r_log_syndrome;
    logic                  r_log_double;

    // Sticky record of the first erroneous word since reset or clear.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clear) begin
            r_log_valid    <= 1'b0;
            r_log_syndrome <= '0;
            r_log_double   <= 1'b0;
        end else if (w_out_fire && (r_err_single || r_err_double) && !r_log_valid) begin
            r_log_valid    <= 1'b1;
            r_log_syndrome <= r_syndrome;
            r_log_double   <= r_err_double;
        end
    end

    assign o_log_valid    = r_log_valid;
    assign o_log_syndrome = r_log_syndrome;
    assign o_log_double   = r_log_double;
`endif

    assign o_valid      = r_s2_valid;
    assign o_data       = r_data;
    assign o_err_single = r_err_single;
    assign o_err_double = r_err_double;
    assign o_syndrome   = r_syndrome;
    assign o_cnt_single = r_cnt_single;
    assign o_cnt_double = r_cnt_double;

endmodule
